// File: rtl/median_stream_3_pkg.sv
// Shared types for the streaming 3-sample median/sort block.
package median_stream_3_pkg;

  // Sample word; compared as unsigned everywhere.
  typedef logic [31:0] data_t;

  // Window fill level, 0..3, saturating at 3.
  typedef logic [1:0] fill_t;

  localparam fill_t FILL_EMPTY = 2'd0;
  localparam fill_t FILL_TWO   = 2'd2;
  localparam fill_t FILL_FULL  = 2'd3;

  // Number of entries in the sliding window.
  localparam int WIN_LEN = 3;

  // Unsigned minimum of two samples.
  function automatic data_t umin(input data_t a, input data_t b);
    return (a < b) ? a : b;
  endfunction

  // Unsigned maximum of two samples.
  function automatic data_t umax(input data_t a, input data_t b);
    return (a < b) ? b : a;
  endfunction

endpackage

// File: rtl/median_stream_3_if.sv
// Sample-in / sorted-window-out handshake bundle.
interface median_stream_3_if;
  import median_stream_3_pkg::*;

  logic  in_valid;
  logic  in_ready;
  data_t in_data;
  logic  in_last;

  logic  out_valid;
  logic  out_ready;
  data_t out_min;
  data_t out_med;
  data_t out_max;
  logic  out_last;

  // Producer of samples / consumer of results.
  modport master (
    output in_valid, in_data, in_last, out_ready,
    input  in_ready, out_valid, out_min, out_med, out_max, out_last
  );

  // The median block itself.
  modport slave (
    input  in_valid, in_data, in_last, out_ready,
    output in_ready, out_valid, out_min, out_med, out_max, out_last
  );

endinterface

// File: rtl/median_3_3_3.sv
// Combinational unsigned sort of three samples.
module median_3_3_3
  import median_stream_3_pkg::*;
(
  input  data_t a_i,
  input  data_t b_i,
  input  data_t c_i,
  output data_t min_o,
  output data_t med_o,
  output data_t max_o
);

  data_t lo_ab;
  data_t hi_ab;

  // Order the first pair, then fold in the third sample. Equal inputs
  // simply yield equal outputs, so ties need no special handling.
  always_comb begin
    lo_ab = umin(a_i, b_i);
    hi_ab = umax(a_i, b_i);
    min_o = umin(lo_ab, c_i);
    max_o = umax(hi_ab, c_i);
    med_o = umax(lo_ab, umin(hi_ab, c_i));
  end

endmodule

// File: rtl/median_stream_3.sv
// Streaming sorter over a 3-sample sliding window, reset at packet ends.
module median_stream_3
  import median_stream_3_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  median_stream_3_if.slave bus,
  output logic [CNT_W-1:0] short_cnt
);

  // Window: index 0 oldest, index 2 newest.
  data_t            win_q [WIN_LEN];
  data_t            win_d [WIN_LEN];
  fill_t            fill_q, fill_d;
  logic [CNT_W-1:0] short_cnt_q, short_cnt_d;

  logic             out_valid_q, out_valid_d;
  logic             out_last_q, out_last_d;
  data_t            out_min_q, out_min_d;
  data_t            out_med_q, out_med_d;
  data_t            out_max_q, out_max_d;

  logic             in_ready;
  logic             in_xfer;
  logic             out_xfer;
  logic             produce;
  logic             window_ready;

  data_t            sort_min, sort_med, sort_max;

  // Sort the two newest stored samples together with the incoming one.
  median_3_3_3 u_sort (
    .a_i   (win_q[1]),
    .b_i   (win_q[2]),
    .c_i   (bus.in_data),
    .min_o (sort_min),
    .med_o (sort_med),
    .max_o (sort_max)
  );

  // Single output register: accept input whenever it is empty or draining.
  assign in_ready     = !out_valid_q || bus.out_ready;
  assign in_xfer      = bus.in_valid && in_ready;
  assign out_xfer     = out_valid_q && bus.out_ready;
  assign window_ready = (fill_q >= FILL_TWO);
  assign produce      = in_xfer && window_ready;

  // Window shifts by one slot on every accepted sample.
  for (genvar gi = 0; gi < WIN_LEN; gi++) begin : g_win
    if (gi < WIN_LEN - 1) begin : g_shift
      assign win_d[gi] = in_xfer ? win_q[gi+1] : win_q[gi];
    end else begin : g_head
      assign win_d[gi] = in_xfer ? bus.in_data : win_q[gi];
    end
  end

  // Next-state for fill, short-packet counter and the output register.
  always_comb begin
    fill_d      = fill_q;
    short_cnt_d = short_cnt_q;
    out_valid_d = out_valid_q;
    out_last_d  = out_last_q;
    out_min_d   = out_min_q;
    out_med_d   = out_med_q;
    out_max_d   = out_max_q;

    if (in_xfer) begin
      if (bus.in_last) begin
        // Packet boundary: the next sample opens a fresh window.
        fill_d = FILL_EMPTY;
        if (!window_ready && (short_cnt_q != '1)) begin
          short_cnt_d = short_cnt_q + 1'b1;
        end
      end else if (fill_q != FILL_FULL) begin
        fill_d = fill_q + 1'b1;
      end
    end

    if (produce) begin
      out_valid_d = 1'b1;
      out_last_d  = bus.in_last;
      out_min_d   = sort_min;
      out_med_d   = sort_med;
      out_max_d   = sort_max;
    end else if (out_xfer) begin
      out_valid_d = 1'b0;
    end
  end

  // State register; reset clears everything without waiting for a clock.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < WIN_LEN; i++) begin
        win_q[i] <= '0;
      end
      fill_q      <= FILL_EMPTY;
      short_cnt_q <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      out_min_q   <= '0;
      out_med_q   <= '0;
      out_max_q   <= '0;
    end else begin
      for (int i = 0; i < WIN_LEN; i++) begin
        win_q[i] <= win_d[i];
      end
      fill_q      <= fill_d;
      short_cnt_q <= short_cnt_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      out_min_q   <= out_min_d;
      out_med_q   <= out_med_d;
      out_max_q   <= out_max_d;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid_q;
  assign bus.out_last  = out_last_q;
  assign bus.out_min   = out_min_q;
  assign bus.out_med   = out_med_q;
  assign bus.out_max   = out_max_q;
  assign short_cnt     = short_cnt_q;

endmodule

// File: doc/median_stream_3.md
MEDIAN_STREAM_3 -- requirements
Module: median_stream_3

Interface
REQ-001 SHALL have parameter CNT_W, 16, width of the short-packet counter.
REQ-002 SHALL have port clk  in  1  sole clock, all state on rising edge.
REQ-003 SHALL have port rst_n  in  1  reset; asynchronous, active-low.
REQ-004 SHALL have port in_valid  in  1  input sample valid.
REQ-005 SHALL have port in_ready  out  1  block accepts input this cycle.
REQ-006 SHALL have port in_data  in  32 (data_t)  input sample, unsigned.
REQ-007 SHALL have port in_last  in  1  marks final sample of a packet.
REQ-008 SHALL have port out_valid  out  1  result valid.
REQ-009 SHALL have port out_ready  in  1  downstream accepts result.
REQ-010 SHALL have port out_min / out_med / out_max  out  32 each (data_t)  sorted 3-sample window.
REQ-011 SHALL have port out_last  out  1  result belongs to last window of packet.
REQ-012 SHALL have port short_cnt  out  CNT_W  count of dropped packets shorter than 3 samples.

Function
REQ-013 Input transfer SHALL occur on a cycle with in_valid && in_ready; output transfer on out_valid && out_ready.
REQ-014 in_ready SHALL equal !out_valid || out_ready (single output register, no skid buffer).
REQ-015 Block SHALL hold a 3-entry window shift register w0 (oldest), w1, w2 (newest) and a fill counter 0..3 (saturates at 3).
REQ-016 On each input transfer: w0<=w1, w1<=w2, w2<=in_data, fill incremented (saturating).
REQ-017 When an input transfer brings the window to 3 valid samples (fill before transfer >= 2), out_min/out_med/out_max SHALL be loaded on that edge with the sorted (w1, w2, in_data) and out_valid set; latency 1 cycle from accepting transfer.
REQ-018 Sorting SHALL be unsigned, ties stable: equal values produce equal outputs, no ordering ambiguity visible.
REQ-019 out_last SHALL be loaded with in_last of the transfer that produced the result.
REQ-020 A packet of N >= 3 samples SHALL produce exactly N-2 results; only the final one has out_last=1.
REQ-021 Input transfer with in_last=1 SHALL clear fill to 0 on the same edge, so the next sample starts a new window (no cross-packet windows).
REQ-022 Input transfer with in_last=1 and fill before transfer < 2 (packet length 1 or 2) SHALL produce no result and increment short_cnt, saturating at all-ones.
REQ-023 While out_valid && !out_ready, all out_* SHALL hold stable and in_ready SHALL be 0.
REQ-024 Simultaneous output transfer and result-producing input transfer SHALL reload the output register in the same cycle (out_valid stays 1, full throughput of 1 result/cycle).
REQ-025 Output transfer with no new result SHALL clear out_valid on that edge.

Reset
REQ-026 rst_n low SHALL immediately clear out_valid, out_last, fill, short_cnt, w0..w2 and out_min/out_med/out_max to 0, independent of clk.
REQ-027 Reset mid-packet SHALL discard the partial window; the first sample after release starts a new packet and is not counted as short.
REQ-028 in_ready SHALL be 1 while in reset and after release (out_valid = 0).

Structure
REQ-029 data_t (32-bit logic) SHALL come from the shared sort package; CNT_W default stays local.
REQ-030 The 3-input sort SHALL be a combinational sub-module instance, median_3_3_3, fed (w1, w2, in_data); the output register lives in median_stream_3.

Verification
REQ-031 Packet 5,1,3,9,7 (last on 7), out_ready=1 -> results (1,3,5),(1,3,9),(3,7,9), out_last only on third; short_cnt 0.
REQ-032 Packets [4,2] last and [8] last -> no out_valid, short_cnt=2; next packet 1,2,3 -> single result (1,2,3) out_last=1.
REQ-033 Continuous packet 10,20,30,40 with out_ready held 0 after first result -> (10,20,30) held stable, in_ready=0; release -> (20,30,40) next cycle.
REQ-034 Values 0xFFFFFFFF,0,0xFFFFFFFF -> (0,0xFFFFFFFF,0xFFFFFFFF), unsigned ordering confirmed; duplicates 7,7,7 -> (7,7,7).
REQ-035 Assert rst_n low after two samples of a packet, asynchronously between edges -> outputs 0 immediately; after release 6,5,4 last -> single result (4,5,6), short_cnt 0.
REQ-036 Random traffic with random out_ready over 1000 samples -> every result equals software model of sorted in-packet windows, no loss or duplication.
